// File: rtl/alu_divider.sv
// Unsigned restoring divider: one quotient bit per clock, MSB first.
// Results are registered only on completion, so intermediate values never appear on the outputs.
module alu_divider #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic             zero
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-1:0] dsr_q, dsr_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rmd_q, rmd_d;
    logic             dbz_q, dbz_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic             accept;
    logic [WIDTH:0]   shifted;
    logic             fits;
    logic [WIDTH-1:0] diff;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values computed by the combinational block.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            dvd_q   <= '0;
            dsr_q   <= '0;
            rem_q   <= '0;
            acc_q   <= '0;
            quo_q   <= '0;
            rmd_q   <= '0;
            dbz_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            dvd_q   <= dvd_d;
            dsr_q   <= dsr_d;
            rem_q   <= rem_d;
            acc_q   <= acc_d;
            quo_q   <= quo_d;
            rmd_q   <= rmd_d;
            dbz_q   <= dbz_d;
            cnt_q   <= cnt_d;
        end
    end

    // The trial subtraction only needs the low WIDTH bits: when it succeeds the
    // true difference is below the divisor, so modular arithmetic is exact.
    always_comb begin
        accept  = start && (state_q != RUN);
        shifted = {rem_q, dvd_q[WIDTH-1]};
        fits    = (shifted >= {1'b0, dsr_q});
        diff    = shifted[WIDTH-1:0] - dsr_q;

        // NOTE: every next-state signal gets a default before the case so no
        // path leaves it unassigned, which would infer a latch.
        state_d = state_q;
        dvd_d   = dvd_q;
        dsr_d   = dsr_q;
        rem_d   = rem_q;
        acc_d   = acc_q;
        quo_d   = quo_q;
        rmd_d   = rmd_q;
        dbz_d   = dbz_q;
        cnt_d   = cnt_q;

        case (state_q)
            RUN: begin
                dvd_d = dvd_q << 1;
                rem_d = fits ? diff : shifted[WIDTH-1:0];
                acc_d = {acc_q[WIDTH-2:0], fits};
                if (cnt_q == '0) begin
                    state_d = DONE;
                    quo_d   = acc_d;
                    rmd_d   = rem_d;
                    dbz_d   = 1'b0;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            IDLE, DONE: begin
                state_d = IDLE;
                if (accept) begin
                    dvd_d = dividend;
                    dsr_d = divisor;
                    rem_d = '0;
                    acc_d = '0;
                    cnt_d = CW'(WIDTH - 1);
                    if (divisor == '0) begin
                        state_d = DONE;
                        quo_d   = '1;
                        rmd_d   = dividend;
                        dbz_d   = 1'b1;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy        = (state_q == RUN);
    assign done        = (state_q == DONE);
    assign quotient    = quo_q;
    assign remainder   = rmd_q;
    assign div_by_zero = dbz_q;
    assign zero        = (quo_q == '0);

endmodule

// File: tb/tb_alu_divider.sv
// Randomised and directed bench for alu_divider against an arithmetic reference
// model (plain / and %), including latency, hold, abort and busy-start cases.
module tb_alu_divider;

    localparam int W = 16;

    logic         clk;
    logic         reset;
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;
    logic         zero;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] prev_q;
    logic [W-1:0] prev_r;
    logic         prev_dbz;

    alu_divider #(.WIDTH(W)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero),
        .zero        (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: what a completed division must report, and after how many edges.
    task automatic model(input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] q, output logic [W-1:0] r,
                         output logic dz, output int lat);
        if (b == 0) begin
            q   = {W{1'b1}};
            r   = a;
            dz  = 1'b1;
            lat = 1;
        end else begin
            q   = a / b;
            r   = a % b;
            dz  = 1'b0;
            lat = W + 1;
        end
    endtask

    task automatic check_reset_values();
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_quotient", quotient, 0);
        check("rst_remainder", remainder, 0);
        check("rst_div_by_zero", div_by_zero, 0);
        check("rst_zero", zero, 1);
    endtask

    // Drive start for one edge; operands are scrambled afterwards to prove they were latched.
    task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        dividend = W'($urandom);
        divisor  = W'($urandom);
    endtask

    // Called at the first negedge after the accepting edge (observation 1).
    task automatic await_result(input logic [W-1:0] a, input logic [W-1:0] b, input int inj_at);
        logic [W-1:0] eq;
        logic [W-1:0] er;
        logic         ed;
        int           elat;
        int           n        = 1;
        int           lat      = 0;
        int           busy_cnt = 0;
        int           hold_err = 0;
        model(a, b, eq, er, ed, elat);
        while (n <= 40 && lat == 0) begin
            if (done) begin
                lat = n;
            end else begin
                if (busy) busy_cnt++;
                if ({quotient, remainder, div_by_zero, zero} !==
                    {prev_q, prev_r, prev_dbz, (prev_q == 0)}) hold_err++;
                if (inj_at != 0 && n == inj_at) begin
                    start    = 1'b1;
                    dividend = 50;
                    divisor  = 5;
                end else begin
                    start = 1'b0;
                end
                @(negedge clk);
                n++;
            end
        end
        start = 1'b0;
        check("done_latency", lat, elat);
        check("busy_cycles", busy_cnt, elat - 1);
        check("outputs_hold_during_run", hold_err, 0);
        check("quotient", quotient, eq);
        check("remainder", remainder, er);
        check("div_by_zero", div_by_zero, ed);
        check("zero_flag", zero, (eq == 0));
        prev_q   = eq;
        prev_r   = er;
        prev_dbz = ed;
    endtask

    task automatic expect_idle_next();
        @(negedge clk);
        check("done_single_pulse", done, 0);
        check("idle_not_busy", busy, 0);
    endtask

    initial begin
        int pulses;
        int busy_seen;
        logic [W-1:0] a;
        logic [W-1:0] b;

        reset    = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        prev_q   = '0;
        prev_r   = '0;
        prev_dbz = 1'b0;

        #1 reset = 1'b1;
        #2 check_reset_values();

        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // First start right after reset release, then the directed corner cases.
        launch(16'd100, 16'd7);
        await_result(16'd100, 16'd7, 0);
        expect_idle_next();

        launch(16'hFFFF, 16'd1);
        await_result(16'hFFFF, 16'd1, 0);
        expect_idle_next();

        launch(16'd5, 16'd0);
        await_result(16'd5, 16'd0, 0);
        expect_idle_next();

        launch(16'd3, 16'd10);
        await_result(16'd3, 16'd10, 0);
        expect_idle_next();

        // Start while busy is ignored; start during DONE is accepted.
        launch(16'd100, 16'd7);
        await_result(16'd100, 16'd7, 5);
        launch(16'd50, 16'd5);
        await_result(16'd50, 16'd5, 0);
        expect_idle_next();

        // Asynchronous reset in the eighth RUN cycle aborts the operation.
        launch(16'd100, 16'd7);
        repeat (7) @(negedge clk);
        #1 reset = 1'b1;
        #1 check_reset_values();
        @(negedge clk);
        reset     = 1'b0;
        pulses    = 0;
        busy_seen = 0;
        repeat (25) begin
            @(negedge clk);
            if (done) pulses++;
            if (busy) busy_seen++;
        end
        check("no_done_after_abort", pulses, 0);
        check("idle_after_abort", busy_seen, 0);
        prev_q   = '0;
        prev_r   = '0;
        prev_dbz = 1'b0;
        launch(16'd9, 16'd3);
        await_result(16'd9, 16'd3, 0);
        expect_idle_next();

        // Random operands; sometimes the next start lands in the DONE cycle.
        for (int i = 0; i < 40; i++) begin
            a = W'($urandom);
            case ($urandom_range(0, 7))
                0:       b = '0;
                1, 2:    b = W'($urandom_range(1, 15));
                3:       b = W'($urandom_range(int'(a), 65535));
                default: b = W'($urandom);
            endcase
            launch(a, b);
            await_result(a, b, 0);
            if ($urandom_range(0, 1) == 0) expect_idle_next();
        end
        expect_idle_next();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
